// File: rtl/spi_reg_ctrl_if.sv
// SPI bus between an external master and the register-bank slave.
interface spi_reg_ctrl_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sck, output cs_n, output mosi, input miso);
  modport slave  (input sck, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that owns the display configuration register bank.
// SCK, CS_N and MOSI are oversampled with clk. A transaction is one command
// byte {rw, addr[6:0]} followed by a burst of data bytes with address
// auto-increment.
module spi_reg_ctrl #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_reg_ctrl_if.slave         spi,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  localparam logic [7:0] NREGS = 8'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sck_prev;
  logic                   rise;
  logic                   fall;
  logic                   armed;

  state_t     state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [6:0] shift, shift_nx;
  logic [7:0] tx_shift, tx_nx;
  logic       rw, rw_nx;
  logic [6:0] addr, addr_nx;
  logic       miso_q, miso_nx;
  logic       we;
  logic [7:0] rx_byte;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  logic [7:0] regs [NUM_REGS];

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_prev;
  assign fall    = ~sck_s & sck_prev;
  assign busy    = ~cs_s;
  assign rx_byte = {shift, mosi_s};
  assign spi.miso = miso_q;

  // Input synchronizers, SCK edge history and the post-reset re-arm flag.
  // The cs_n pipeline resets to "deselected"; fill marks when it holds real
  // samples so a transaction already in flight at reset release stays ignored
  // until cs_n is genuinely observed high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      sck_prev  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      sck_prev  <= sck_s;
      if (cs_s && fill[SYNC_STAGES-1]) begin
        armed <= 1'b1;
      end
    end
  end

  // Readback address: the command's start address while finishing CMD,
  // otherwise the next address of the burst.
  always_comb begin
    rd_addr = (state == CMD) ? rx_byte[6:0] : addr + 7'd1;
  end

  // Register readback mux; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 7'(i)) begin
        rd_data = regs[i];
      end
    end
  end

  // FSM next-state and datapath updates; deselect overrides any SCK edge.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    tx_nx      = tx_shift;
    rw_nx      = rw;
    addr_nx    = addr;
    miso_nx    = miso_q;
    we         = 1'b0;
    if (cs_s) begin
      state_nx   = IDLE;
      bit_cnt_nx = '0;
      miso_nx    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          miso_nx    = 1'b0;
          bit_cnt_nx = '0;
          if (armed) begin
            state_nx = CMD;
          end
        end
        CMD: begin
          if (rise) begin
            shift_nx   = rx_byte[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw_nx      = rx_byte[7];
              addr_nx    = rx_byte[6:0];
              bit_cnt_nx = '0;
              state_nx   = DATA;
              if (rx_byte[7]) begin
                tx_nx = rd_data;
              end
            end
          end
        end
        DATA: begin
          if (rise) begin
            shift_nx   = rx_byte[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (!rw && ({1'b0, addr} < NREGS)) begin
                we = 1'b1;
              end
              if (rw) begin
                tx_nx = rd_data;
              end
              addr_nx    = addr + 7'd1;
              bit_cnt_nx = '0;
            end
          end else if (fall && rw) begin
            miso_nx = tx_shift[7];
            tx_nx   = {tx_shift[6:0], 1'b0};
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM state and transaction datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_shift <= '0;
      rw       <= 1'b0;
      addr     <= '0;
      miso_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      shift    <= shift_nx;
      tx_shift <= tx_nx;
      rw       <= rw_nx;
      addr     <= addr_nx;
      miso_q   <= miso_nx;
    end
  end

  // Register bank write with strobe and address report in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= we;
      if (we) begin
        wr_addr <= addr;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (addr == 7'(i)) begin
            regs[i] <= rx_byte;
          end
        end
      end
    end
  end

  // Flatten the bank for the display datapath.
  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_flat[8*i +: 8] = regs[i];
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: the stimulus pushes expected writes and
// readback bytes; a monitor pops and compares as the DUT produces them.
module tb_spi_reg_ctrl;
  localparam int HALF = 80;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] regs_flat;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        busy;
  logic [7:0]  rx;

  int total = 0;
  int bad   = 0;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd[$];

  spi_reg_ctrl_if spi_bus ();

  spi_reg_ctrl #(
    .NUM_REGS   (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (spi_bus.slave),
    .regs_flat(regs_flat),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: match write strobes and received readback bytes to expectations.
  initial begin
    wr_t        e;
    logic [7:0] g;
    forever begin
      @(negedge clk);
      if (wr_strobe === 1'b1) begin
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL strobe_unexpected: got strobe at addr %0h expected none", wr_addr);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", (regs_flat >> (8 * wr_addr)) & 32'hFF, 32'(e.data));
        end
      end
      while (got_rd.size() > 0) begin
        g = got_rd.pop_front();
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got %0h expected none", g);
        end else begin
          chk("rd_byte", 32'(g), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  // Mode-0 master: drive MOSI while SCK low, sample MISO on the rising edge.
  task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      spi_bus.mosi = v[7-i];
      #HALF;
      spi_bus.sck = 1'b1;
      r = {r[6:0], spi_bus.miso};
      #HALF;
      spi_bus.sck = 1'b0;
    end
  endtask

  task automatic start_xfer();
    @(posedge clk);
    #2;
    spi_bus.cs_n = 1'b0;
    #HALF;
  endtask

  task automatic stop_xfer();
    #HALF;
    spi_bus.cs_n = 1'b1;
    #(HALF * 2);
  endtask

  task automatic write2(input logic [7:0] cmd, input logic [7:0] d);
    start_xfer();
    spi_bits(cmd, 8, rx);
    spi_bits(d, 8, rx);
    stop_xfer();
  endtask

  initial begin
    spi_bus.sck  = 1'b0;
    spi_bus.cs_n = 1'b1;
    spi_bus.mosi = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_regs", regs_flat, 32'h0);
    chk("rst_miso", 32'(spi_bus.miso), 32'h0);
    chk("rst_strobe", 32'(wr_strobe), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single write
    exp_wr.push_back({7'd1, 8'hA5});
    write2(8'h01, 8'hA5);
    chk("write_regs", regs_flat, 32'h0000_A500);
    chk("write_pending", 32'(exp_wr.size()), 32'h0);

    // Burst write across all registers
    exp_wr.push_back({7'd0, 8'h11});
    exp_wr.push_back({7'd1, 8'h22});
    exp_wr.push_back({7'd2, 8'h33});
    exp_wr.push_back({7'd3, 8'h44});
    start_xfer();
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    spi_bits(8'h33, 8, rx);
    spi_bits(8'h44, 8, rx);
    stop_xfer();
    chk("burst_regs", regs_flat, 32'h4433_2211);
    chk("burst_pending", 32'(exp_wr.size()), 32'h0);

    // Preload reg2, then burst read from 2 running past the last register
    exp_wr.push_back({7'd2, 8'h3C});
    write2(8'h02, 8'h3C);
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'h44);
    exp_rd.push_back(8'h00);
    start_xfer();
    chk("busy_active", 32'(busy), 32'h1);
    spi_bits(8'h82, 8, rx);
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'h00, 8, rx);
      got_rd.push_back(rx);
    end
    stop_xfer();
    chk("busy_idle", 32'(busy), 32'h0);
    chk("read_miso_idle", 32'(spi_bus.miso), 32'h0);

    // Read of an out-of-range address
    exp_rd.push_back(8'h00);
    start_xfer();
    spi_bits(8'h85, 8, rx);
    spi_bits(8'h00, 8, rx);
    got_rd.push_back(rx);
    stop_xfer();
    chk("read_regs", regs_flat, 32'h443C_2211);

    // Abort after 5 data bits, then a full write
    start_xfer();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'hFF, 5, rx);
    stop_xfer();
    chk("abort_regs", regs_flat, 32'h443C_2211);
    exp_wr.push_back({7'd1, 8'h7E});
    write2(8'h01, 8'h7E);
    chk("after_abort_regs", regs_flat, 32'h443C_7E11);

    // Out-of-range write
    write2(8'h10, 8'hFF);
    chk("oor_regs", regs_flat, 32'h443C_7E11);
    chk("oor_miso", 32'(spi_bus.miso), 32'h0);

    // Reset during the 4th data bit of a write
    start_xfer();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hFF, 3, rx);
    spi_bus.mosi = 1'b1;
    #HALF;
    spi_bus.sck = 1'b1;
    #(HALF / 2);
    rst_n = 1'b0;
    #20;
    chk("midrst_regs", regs_flat, 32'h0);
    chk("midrst_strobe", 32'(wr_strobe), 32'h0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_miso", 32'(spi_bus.miso), 32'h0);
    #(HALF / 2 - 20);
    spi_bus.sck = 1'b0;
    #20;
    rst_n = 1'b1;
    spi_bits(8'hFF, 4, rx);
    spi_bits(8'h55, 8, rx);
    stop_xfer();
    chk("postrst_regs", regs_flat, 32'h0);
    exp_wr.push_back({7'd0, 8'h5A});
    write2(8'h00, 8'h5A);
    chk("postrst_write_regs", regs_flat, 32'h0000_005A);

    repeat (10) @(posedge clk);
    chk("final_wr_pending", 32'(exp_wr.size()), 32'h0);
    chk("final_rd_pending", 32'(exp_rd.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
